// File: rtl/multibyte_add_seq.sv
// Byte-serial adder: adds two NBYTES-wide operands one byte per clock and
// presents the sum, carry-out and signed overflow through a valid/ready handshake.
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int IDXW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry into bit 7 of a byte add, recovered from the operand and sum bits.
    function automatic logic carry_into_msb(input logic [7:0] x, input logic [7:0] y,
                                            input logic [7:0] s);
        return x[7] ^ y[7] ^ s[7];
    endfunction

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [NBYTES-1:0][7:0]  r_a;
    logic [NBYTES-1:0][7:0]  r_b;
    logic [NBYTES-1:0][7:0]  r_sum;
    logic [IDXW-1:0]         r_idx;
    logic                    r_carry;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    r_idle;
    logic                    r_out_valid;
    logic                    r_busy;
    logic [7:0]              w_a_byte;
    logic [7:0]              w_b_byte;
    logic [8:0]              w_byte_add;
    logic                    w_last;
    logic                    w_accept;

    // in_ready is forced low while reset is held, otherwise it is the registered idle flag.
    assign in_ready  = r_idle & rst_n;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Operand byte selection by compare, so an out-of-range index can never be used.
    always_comb begin
        w_a_byte = 8'h00;
        w_b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            w_a_byte = (r_idx == IDXW'(i)) ? r_a[i] : w_a_byte;
            w_b_byte = (r_idx == IDXW'(i)) ? r_b[i] : w_b_byte;
        end
        w_byte_add = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'h00, r_carry};
        w_last     = (r_idx == IDXW'(NBYTES - 1));
        w_accept   = in_valid & r_idle & rst_n;
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = ST_RUN;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Handshake and status flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle      <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_idle      <= (w_state_nx == ST_IDLE);
            r_out_valid <= (w_state_nx == ST_DONE);
            r_busy      <= (w_state_nx != ST_IDLE);
        end
    end

    // Operand capture and one byte of the ripple add per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_sum[i] <= w_byte_add[7:0];
                        end
                    end
                    r_carry <= w_byte_add[8];
                    if (w_last) begin
                        r_cout <= w_byte_add[8];
                        r_ovf  <= carry_into_msb(w_a_byte, w_b_byte, w_byte_add[7:0])
                                  ^ w_byte_add[8];
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq: a 4-byte and a 1-byte instance, each
// checked against plain-arithmetic expectations queued at accept time.
module tb_multibyte_add_seq;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic        cout, ovf, busy;
    logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, out_ready1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0, sum1;
    logic        cout1, ovf1, busy1;

    int   n_tests = 0, n_fail = 0, cyc = 0;
    exp_t q[$], q1[$];
    bit   bp_mode = 1'b1, ready_force = 1'b0;

    multibyte_add_seq #(.NBYTES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy));

    multibyte_add_seq #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
    endtask

    // Reference model: whole-word arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input int nb, input logic [31:0] x, input logic [31:0] y,
                                   input logic c);
        exp_t        e;
        logic [32:0] full;
        int          w;
        w    = 8 * nb;
        full = {1'b0, x} + {1'b0, y} + {32'h0, c};
        e.s  = (nb == 4) ? full[31:0] : {24'h0, full[7:0]};
        e.co = full[w];
        e.ov = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input bit push);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 500);
        if (!in_ready) begin
            flag_fail("accept_timeout");
        end else if (push) begin
            e = model(4, ta, tb_v, tc);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        in_valid1 = 1'b1; a1 = ta; b1 = tb_v; cin1 = tc;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready1 && n < 500);
        if (!in_ready1) begin
            flag_fail("accept1_timeout");
        end else begin
            e = model(1, {24'h0, ta}, {24'h0, tb_v}, tc);
            e.acc = cyc + 1;
            q1.push_back(e);
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    // Consumer: random backpressure, or a forced level during directed holds.
    always @(posedge clk) begin
        #2;
        out_ready  = bp_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        out_ready1 = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    bit prev_ov = 1'b0, hs_prev = 1'b0, prev_ov1 = 1'b0;
    exp_t m, m1;

    // Monitor for the 4-byte instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("ready_after_hs", {31'h0, in_ready}, 32'd1);
                chk("valid_after_hs", {31'h0, out_valid}, 32'd0);
            end
            hs_prev = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    flag_fail("unexpected_valid");
                end else begin
                    m = q[0];
                    if (!prev_ov) chk("latency", cyc, m.acc + 4);
                    chk("sum", sum, m.s);
                    chk("cout", {31'h0, cout}, {31'h0, m.co});
                    chk("ovf", {31'h0, ovf}, {31'h0, m.ov});
                    chk("in_ready_done", {31'h0, in_ready}, 32'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // Monitor for the 1-byte instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov1 = 1'b0;
        end else begin
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    flag_fail("unexpected_valid1");
                end else begin
                    m1 = q1[0];
                    if (!prev_ov1) chk("latency1", cyc, m1.acc + 1);
                    chk("sum1", {24'h0, sum1}, m1.s);
                    chk("cout1", {31'h0, cout1}, {31'h0, m1.co});
                    chk("ovf1", {31'h0, ovf1}, {31'h0, m1.ov});
                    if (out_ready1) void'(q1.pop_front());
                end
            end
            prev_ov1 = out_valid1;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q1.size() != 0 || busy || busy1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || q1.size() != 0) flag_fail("drain_timeout");
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          n;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout_ovf", {30'h0, cout, ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'h0, in_ready}, 32'd1);

        // Directed corner operands.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

        // Randomized operands, including full carry chains.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        // Backpressure hold with new operands offered during DONE.
        bp_mode = 1'b0;
        ready_force = 1'b0;
        send(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) flag_fail("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
            chk("bp_valid_held", {31'h0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        ready_force = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ready_force = 1'b0;
        @(negedge clk);
        chk("bp_busy_after_hs", {31'h0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("bp_not_accepted", {31'h0, busy}, 32'd0);
        chk("bp_queue_empty", q.size(), 32'd0);

        // Reset in the middle of RUN abandons the operation.
        send(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_run_busy", {31'h0, busy}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_run_in_ready", {31'h0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abandon_sum", sum, 32'd0);
        chk("abandon_valid", {31'h0, out_valid}, 32'd0);
        chk("abandon_busy", {31'h0, busy}, 32'd0);
        chk("abandon_in_ready", {31'h0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        bp_mode = 1'b1;

        // Single-byte instance.
        send1(8'h80, 8'h80, 1'b0);
        send1(8'h7F, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
